// File: rtl/ctl_status_writer_if.sv
// Status-writer bundle: live status inputs, BRAM write port and the REQ/GNT handshake.
// master = the writer itself; slave = the arbiter/BRAM/host side.
interface ctl_status_writer_if #(
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                  trigger;
  logic                  thermo;
  logic                  force_fan;
  logic                  mod_segment;
  logic                  stm_segment;
  logic                  stm_mode;
  logic [14:0]           mod_idx;
  logic [12:0]           stm_idx;
  logic [31:0]           sys_time;
  logic                  bus_req;
  logic                  bus_gnt;
  logic                  bram_we;
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic [15:0]           bram_din;
  logic                  busy;
  logic                  done;
  logic [15:0]           seq;

  modport master (
    input  trigger, thermo, force_fan, mod_segment, stm_segment, stm_mode,
    input  mod_idx, stm_idx, sys_time, bus_gnt,
    output bus_req, bram_we, bram_addr, bram_din, busy, done, seq
  );

  modport slave (
    output trigger, thermo, force_fan, mod_segment, stm_segment, stm_mode,
    output mod_idx, stm_idx, sys_time, bus_gnt,
    input  bus_req, bram_we, bram_addr, bram_din, busy, done, seq
  );
endinterface

// File: rtl/ctl_status_writer.sv
// Snapshots live status and writes it to BRAM as a seqlock burst (odd SEQ, 5 data words, even SEQ).
// First write 3 cycles after trigger with GNT held; GNT low pauses the burst at the same word.
module ctl_status_writer #(
  parameter int unsigned           ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h80,
  parameter logic [31:0]           PERIOD     = 32'd0
) (
  input  logic                    clk,
  input  logic                    rst,
  ctl_status_writer_if.master     bus
);

  typedef enum logic [1:0] {IDLE, REQ, WRITE} state_t;

  state_t                state_q, state_d;
  logic [2:0]            k_q, k_d;
  logic                  pend_q, pend_d;
  logic [31:0]           timer_q, timer_d;
  logic [15:0]           seq_q, seq_d;
  logic [4:0]            snap_flags_q, snap_flags_d;
  logic [14:0]           snap_mod_q, snap_mod_d;
  logic [12:0]           snap_stm_q, snap_stm_d;
  logic [31:0]           snap_time_q, snap_time_d;
  logic                  req_q, req_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           din_q, din_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  fire;
  logic                  trig;

  always_comb begin
    fire         = 1'b0;
    timer_d      = '0;
    state_d      = state_q;
    k_d          = k_q;
    seq_d        = seq_q;
    snap_flags_d = snap_flags_q;
    snap_mod_d   = snap_mod_q;
    snap_stm_d   = snap_stm_q;
    snap_time_d  = snap_time_q;
    req_d        = req_q;
    we_d         = 1'b0;
    addr_d       = addr_q;
    din_d        = din_q;
    busy_d       = busy_q;
    done_d       = 1'b0;

    // Free-running timer: keeps counting through bursts so the trigger cadence never drifts.
    if (PERIOD != 32'd0) begin
      fire    = (timer_q == PERIOD - 32'd1);
      timer_d = fire ? 32'd0 : timer_q + 32'd1;
    end
    trig   = bus.trigger | fire;
    pend_d = pend_q | (trig & (state_q != IDLE));

    unique case (state_q)
      IDLE: begin
        if (trig || pend_q) begin
          snap_flags_d = {bus.stm_mode, bus.stm_segment, bus.mod_segment, bus.force_fan, bus.thermo};
          snap_mod_d   = bus.mod_idx;
          snap_stm_d   = bus.stm_idx;
          snap_time_d  = bus.sys_time;
          pend_d       = 1'b0;
          k_d          = 3'd0;
          busy_d       = 1'b1;
          req_d        = 1'b1;
          state_d      = REQ;
        end
      end
      REQ: begin
        if (bus.bus_gnt) state_d = WRITE;
      end
      WRITE: begin
        if (k_q == 3'd7) begin
          seq_d   = seq_q + 16'd2;
          done_d  = 1'b1;
          req_d   = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (bus.bus_gnt) begin
          we_d   = 1'b1;
          k_d    = k_q + 3'd1;
          addr_d = (k_q == 3'd6) ? BASE_ADDR : BASE_ADDR + ADDR_WIDTH'(k_q);
          unique case (k_q)
            3'd0:    din_d = seq_q + 16'd1;
            3'd1:    din_d = {11'b0, snap_flags_q};
            3'd2:    din_d = {1'b0, snap_mod_q};
            3'd3:    din_d = {3'b0, snap_stm_q};
            3'd4:    din_d = snap_time_q[15:0];
            3'd5:    din_d = snap_time_q[31:16];
            default: din_d = seq_q + 16'd2;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      k_q          <= '0;
      pend_q       <= 1'b0;
      timer_q      <= '0;
      seq_q        <= '0;
      snap_flags_q <= '0;
      snap_mod_q   <= '0;
      snap_stm_q   <= '0;
      snap_time_q  <= '0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      din_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      pend_q       <= pend_d;
      timer_q      <= timer_d;
      seq_q        <= seq_d;
      snap_flags_q <= snap_flags_d;
      snap_mod_q   <= snap_mod_d;
      snap_stm_q   <= snap_stm_d;
      snap_time_q  <= snap_time_d;
      req_q        <= req_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      din_q        <= din_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.bus_req   = req_q;
  assign bus.bram_we   = we_q;
  assign bus.bram_addr = addr_q;
  assign bus.bram_din  = din_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.seq       = seq_q;

endmodule

// File: tb/tb_ctl_status_writer.sv
// Bench for ctl_status_writer: expected BRAM writes are queued at trigger time and checked as they appear.
module tb_ctl_status_writer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ctl_status_writer_if #(.ADDR_WIDTH(8)) sif ();
  ctl_status_writer_if #(.ADDR_WIDTH(8)) pif ();

  ctl_status_writer #(.ADDR_WIDTH(8), .BASE_ADDR(8'h80), .PERIOD(32'd0)) dut (
    .clk(clk), .rst(rst), .bus(sif));
  ctl_status_writer #(.ADDR_WIDTH(8), .BASE_ADDR(8'h80), .PERIOD(32'd20)) dut_p (
    .clk(clk), .rst(rst), .bus(pif));

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] din;
  } wr_t;

  wr_t         sb_q[$];
  wr_t         sb_e;
  int          tests_run = 0;
  int          failed    = 0;
  logic [15:0] exp_seq;
  logic [4:0]  cur_flags;
  logic [14:0] cur_mod;
  logic [12:0] cur_stm;
  logic [31:0] cur_time;

  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
    end else if (sif.bram_we) begin
      tests_run++;
      if (sb_q.size() == 0) begin
        failed++;
        $display("FAIL sb_unexpected_write got addr=%h din=%h required no write", sif.bram_addr, sif.bram_din);
      end else begin
        sb_e = sb_q.pop_front();
        if (sif.bram_addr !== sb_e.addr || sif.bram_din !== sb_e.din) begin
          failed++;
          $display("FAIL sb_write got addr=%h din=%h required addr=%h din=%h",
                   sif.bram_addr, sif.bram_din, sb_e.addr, sb_e.din);
        end
      end
    end
  end

  task automatic drive_inputs(input logic [4:0] f, input logic [14:0] mi, input logic [12:0] si,
                              input logic [31:0] tm);
    {sif.stm_mode, sif.stm_segment, sif.mod_segment, sif.force_fan, sif.thermo} = f;
    sif.mod_idx  = mi;
    sif.stm_idx  = si;
    sif.sys_time = tm;
    cur_flags = f; cur_mod = mi; cur_stm = si; cur_time = tm;
  endtask

  task automatic push_burst(input logic [15:0] s);
    logic [15:0] s1, s2;
    s1 = s + 16'd1;
    s2 = s + 16'd2;
    sb_q.push_back('{addr: 8'h80, din: s1});
    sb_q.push_back('{addr: 8'h81, din: {11'b0, cur_flags}});
    sb_q.push_back('{addr: 8'h82, din: {1'b0, cur_mod}});
    sb_q.push_back('{addr: 8'h83, din: {3'b0, cur_stm}});
    sb_q.push_back('{addr: 8'h84, din: cur_time[15:0]});
    sb_q.push_back('{addr: 8'h85, din: cur_time[31:16]});
    sb_q.push_back('{addr: 8'h80, din: s2});
  endtask

  task automatic wait_done(input int max_cyc, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(posedge clk); #1;
      if (sif.done) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sif.trigger = 1'b0; sif.bus_gnt = 1'b1;
    pif.trigger = 1'b0; pif.bus_gnt = 1'b1;
    pif.thermo = 1'b0; pif.force_fan = 1'b0; pif.mod_segment = 1'b0; pif.stm_segment = 1'b0;
    pif.stm_mode = 1'b0; pif.mod_idx = '0; pif.stm_idx = '0; pif.sys_time = '0;
    drive_inputs(5'h00, 15'h0, 13'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({sif.bus_req, sif.bram_we, sif.busy, sif.done} !== 4'b0000) begin
      failed++;
      $display("FAIL reset_ctl got req/we/busy/done=%b required 0000",
               {sif.bus_req, sif.bram_we, sif.busy, sif.done});
    end
    tests_run++;
    if (sif.seq !== 16'h0000 || sif.bram_addr !== 8'h00 || sif.bram_din !== 16'h0000) begin
      failed++;
      $display("FAIL reset_data got seq=%h addr=%h din=%h required all 0", sif.seq, sif.bram_addr, sif.bram_din);
    end
    rst = 1'b0;
    exp_seq = 16'h0000;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic exp_act;
    drive_inputs(5'h15, 15'h1234, 13'h0ABC, 32'hDEADBEEF);
    push_burst(exp_seq);
    sif.trigger = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (i == 1) sif.trigger = 1'b0;
      if (i == 4) sif.mod_idx = 15'h7777;  // must not leak into the running burst
      tests_run++;
      if (sif.bram_we !== (i >= 3 && i <= 9)) begin
        failed++;
        $display("FAIL basic_we cyc=t+%0d got %b required %b", i, sif.bram_we, (i >= 3 && i <= 9));
      end
      tests_run++;
      if (sif.done !== (i == 10)) begin
        failed++;
        $display("FAIL basic_done cyc=t+%0d got %b required %b", i, sif.done, (i == 10));
      end
      exp_act = (i >= 1 && i <= 9);
      tests_run++;
      if (sif.busy !== exp_act || sif.bus_req !== exp_act) begin
        failed++;
        $display("FAIL basic_busy_req cyc=t+%0d got busy=%b req=%b required %b", i, sif.busy, sif.bus_req, exp_act);
      end
    end
    exp_seq = exp_seq + 16'd2;
    tests_run++;
    if (sif.seq !== exp_seq || sb_q.size() != 0) begin
      failed++;
      $display("FAIL basic_seq got seq=%h left=%0d required seq=%h left=0", sif.seq, sb_q.size(), exp_seq);
    end
  endtask

  task automatic test_gnt_pause();
    int  writes;
    logic exp_we;
    writes = 0;
    drive_inputs(5'h0A, 15'h5A5A, 13'h1F00, 32'h01234567);
    push_burst(exp_seq);
    sif.trigger = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      if (i == 1) sif.trigger = 1'b0;
      if (sif.bram_we) writes++;
      exp_we = (i >= 3 && i <= 5) || (i >= 9 && i <= 12);
      tests_run++;
      if (sif.bram_we !== exp_we || sif.done !== (i == 13) || sif.bus_req !== (i <= 12)) begin
        failed++;
        $display("FAIL pause_cycle cyc=t+%0d got we=%b done=%b req=%b required we=%b done=%b req=%b",
                 i, sif.bram_we, sif.done, sif.bus_req, exp_we, (i == 13), (i <= 12));
      end
      if (i == 5) sif.bus_gnt = 1'b0;
      if (i == 8) sif.bus_gnt = 1'b1;
    end
    exp_seq = exp_seq + 16'd2;
    tests_run++;
    if (writes != 7 || sif.seq !== exp_seq) begin
      failed++;
      $display("FAIL pause_total got writes=%0d seq=%h required writes=7 seq=%h", writes, sif.seq, exp_seq);
    end
  endtask

  task automatic test_coalesce();
    int dones;
    dones = 0;
    drive_inputs(5'h1F, 15'h0001, 13'h0002, 32'h00030004);
    push_burst(exp_seq);
    sif.trigger = 1'b1;
    for (int i = 1; i <= 26; i++) begin
      @(posedge clk); #1;
      sif.trigger = (i == 3 || i == 5 || i == 7);
      if (i == 4) begin
        drive_inputs(5'h03, 15'h7ABC, 13'h1234, 32'hCAFEF00D);
        push_burst(exp_seq + 16'd2);
      end
      if (sif.done) dones++;
      if (i == 10) begin
        tests_run++;
        if (sif.done !== 1'b1 || sif.busy !== 1'b0 || sif.bus_req !== 1'b0) begin
          failed++;
          $display("FAIL coalesce_dip got done=%b busy=%b req=%b required 1,0,0", sif.done, sif.busy, sif.bus_req);
        end
      end
      if (i == 11) begin
        tests_run++;
        if (sif.busy !== 1'b1 || sif.bus_req !== 1'b1) begin
          failed++;
          $display("FAIL coalesce_rearm got busy=%b req=%b required 1,1", sif.busy, sif.bus_req);
        end
      end
    end
    exp_seq = exp_seq + 16'd4;
    tests_run++;
    if (dones != 2 || sif.seq !== exp_seq || sb_q.size() != 0) begin
      failed++;
      $display("FAIL coalesce_total got dones=%0d seq=%h left=%0d required dones=2 seq=%h left=0",
               dones, sif.seq, sb_q.size(), exp_seq);
    end
  endtask

  task automatic test_seq_wrap();
    bit seen;
    // Reaching 0xFFFE by bursts alone would take ~330k cycles, so the counter is preset while idle.
    force dut.seq_q = 16'hFFFE;
    @(posedge clk); #1;
    release dut.seq_q;
    @(posedge clk); #1;
    exp_seq = 16'hFFFE;
    tests_run++;
    if (sif.seq !== exp_seq) begin
      failed++;
      $display("FAIL wrap_preload got seq=%h required %h", sif.seq, exp_seq);
    end
    drive_inputs(5'h11, 15'h4321, 13'h0777, 32'h89ABCDEF);
    push_burst(exp_seq);
    sif.trigger = 1'b1;
    @(posedge clk); #1;
    sif.trigger = 1'b0;
    wait_done(30, seen);
    exp_seq = exp_seq + 16'd2;
    tests_run++;
    if (!seen || sif.seq !== exp_seq || sb_q.size() != 0) begin
      failed++;
      $display("FAIL wrap_seq got done_seen=%b seq=%h left=%0d required 1 seq=%h left=0",
               seen, sif.seq, sb_q.size(), exp_seq);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    drive_inputs(5'h04, 15'h0F0F, 13'h00FF, 32'h11112222);
    push_burst(exp_seq);
    sif.trigger = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      @(posedge clk); #1;
      if (i == 1) sif.trigger = 1'b0;
    end
    tests_run++;
    if (sif.bram_we !== 1'b1 || sif.bram_addr !== 8'h84) begin
      failed++;
      $display("FAIL rstmid_k4 got we=%b addr=%h required we=1 addr=84", sif.bram_we, sif.bram_addr);
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if (sif.bram_we !== 1'b0 || sif.bus_req !== 1'b0 || sif.busy !== 1'b0) begin
      failed++;
      $display("FAIL rstmid_async got we=%b req=%b busy=%b required 0,0,0", sif.bram_we, sif.bus_req, sif.busy);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_seq = 16'h0000;
    @(posedge clk); #1;
    drive_inputs(5'h08, 15'h2468, 13'h1357, 32'h0BADBEEF);
    push_burst(exp_seq);
    sif.trigger = 1'b1;
    @(posedge clk); #1;
    sif.trigger = 1'b0;
    wait_done(30, seen);
    exp_seq = exp_seq + 16'd2;
    tests_run++;
    if (!seen || sif.seq !== exp_seq || sb_q.size() != 0) begin
      failed++;
      $display("FAIL rstmid_after got done_seen=%b seq=%h left=%0d required 1 seq=%h left=0",
               seen, sif.seq, sb_q.size(), exp_seq);
    end
  endtask

  task automatic test_periodic();
    int dones;
    int writes;
    dones = 0;
    writes = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 1; i <= 115; i++) begin
      @(posedge clk); #1;
      if (pif.done) dones++;
      if (pif.bram_we) writes++;
    end
    tests_run++;
    if (dones != 5 || writes != 35) begin
      failed++;
      $display("FAIL periodic_count got dones=%0d writes=%0d required dones=5 writes=35", dones, writes);
    end
    tests_run++;
    if (pif.seq !== 16'h000A) begin
      failed++;
      $display("FAIL periodic_seq got %h required 000a", pif.seq);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gnt_pause();
    test_coalesce();
    test_seq_wrap();
    test_reset_mid();
    test_periodic();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
